// File: rtl/mem_responder_pkg.sv
// Shared widths and enumerations for the memory responder slice.
package mem_responder_pkg;

  localparam int unsigned LINE_W     = 128;
  localparam int unsigned MEM_ADDR_W = 28;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_e;

  typedef enum logic {OP_READ, OP_WRITE} op_e;

endpackage

// File: rtl/mem_responder_if.sv
// Line-granular memory bus between the cache controller (master) and memory (slave).
// With MEM_RANGE_CHECK_EN defined the bus also carries mem_err.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]     mem_wdata;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  mem_ready;
`ifdef MEM_RANGE_CHECK_EN
  logic                  mem_err;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mem_err
  );
  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mem_err
  );
`else
  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );
  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
`endif

endinterface

// File: rtl/mem_line_array.sv
// 2^DEPTH_W x LINE_W synchronous line storage with registered read data.
// Storage is not reset; only the read data register is.
module mem_line_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [DEPTH_W-1:0] waddr_i,
  input  logic [LINE_W-1:0]  wdata_i,
  input  logic               re_i,
  input  logic               rclr_i,
  input  logic [DEPTH_W-1:0] raddr_i,
  output logic [LINE_W-1:0]  rdata_o
);

  localparam int unsigned Depth = 1 << DEPTH_W;

  logic [LINE_W-1:0] mem_q [Depth];
  logic [LINE_W-1:0] rdata_q;

  // Line write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data register; holds its value until the next read, rclr_i forces zeros.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rclr_i ? '0 : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency slow-memory responder for the cache line interface.
// Optional MEM_RANGE_CHECK_EN: flags and neutralises accesses with address bits above the
// storage index set (mem_err in the RESP cycle).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH_W = 8
) (
  input logic            clk,
  input logic            proc_reset,
  mem_responder_if.slave mem_if
);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  op_e                   op_q, op_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic                  commit;
  logic                  range_err_d;
  logic                  range_err_q;

  // Next state; commit marks the edge that enters RESP, where storage is accessed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_if.mem_write || mem_if.mem_read) begin
          op_d    = mem_if.mem_write ? OP_WRITE : OP_READ;
          addr_d  = mem_if.mem_addr;
          wdata_d = mem_if.mem_wdata;
          cnt_d   = 8'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // Leave when the decremented count hits zero so mem_ready lands in cycle LATENCY.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, counter and latched request.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign range_err_d = |addr_d[MEM_ADDR_W-1:DEPTH_W];
  assign range_err_q = |addr_q[MEM_ADDR_W-1:DEPTH_W];

`ifdef MEM_RANGE_CHECK_EN
  logic we, rclr;
  assign we             = commit && (op_d == OP_WRITE) && !range_err_d;
  assign rclr           = range_err_d;
  assign mem_if.mem_err = (state_q == RESP) && range_err_q;
`else
  logic we, rclr;
  logic unused_range;
  assign we           = commit && (op_d == OP_WRITE);
  assign rclr         = 1'b0;
  assign unused_range = range_err_d ^ range_err_q;
`endif

  mem_line_array #(
    .DEPTH_W (DEPTH_W)
  ) u_line_array (
    .clk_i   (clk),
    .rst_i   (proc_reset),
    .we_i    (we),
    .waddr_i (addr_d[DEPTH_W-1:0]),
    .wdata_i (wdata_d),
    .re_i    (commit && (op_d == OP_READ)),
    .rclr_i  (rclr),
    .raddr_i (addr_d[DEPTH_W-1:0]),
    .rdata_o (mem_if.mem_rdata)
  );

  assign mem_if.mem_ready = (state_q == RESP);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=4, DEPTH_W=8).
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam logic [127:0] DataA = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] Data6 = 128'h6666_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] Ones  = {128{1'b1}};
  localparam logic [127:0] Fives = {32{4'h5}};
  localparam logic [127:0] As    = {32{4'hA}};
  localparam logic [127:0] DataP = 128'hFACE_B00C_DEAD_BEEF_CAFE_F00D_1234_5678;

  logic clk = 1'b0;
  logic proc_reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_responder_if bus ();

  mem_responder #(
    .LATENCY (4),
    .DEPTH_W (8)
  ) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .mem_if     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic get_err();
`ifdef MEM_RANGE_CHECK_EN
    return bus.mem_err;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one request just after a rising edge (that cycle is cycle 0), wait for mem_ready,
  // drop the request, and confirm the pulse is one cycle wide.
  task automatic req(input logic wr, input logic rd, input logic [27:0] addr,
                     input logic [127:0] wdata, output int lat, output logic [127:0] rdat,
                     output logic err);
    lat  = -1;
    rdat = '0;
    err  = 1'b0;
    bus.mem_write = wr;
    bus.mem_read  = rd;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        lat  = k;
        rdat = bus.mem_rdata;
        err  = get_err();
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat < 0) begin
      check("req_timeout", 128'd1, 128'd0);
    end
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    @(negedge clk);
    check("single_pulse", 128'(bus.mem_ready), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int           lat;
    logic [127:0] rdat;
    logic         err;
    int           first, second, pulses;
    logic [127:0] rd2;

    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(bus.mem_ready), 128'd0);
    check("rst_rdata", bus.mem_rdata, 128'd0);
    check("rst_err", 128'(get_err()), 128'd0);
    proc_reset = 1'b0;
    @(posedge clk);
    #1;

    // Write line 5, read it back, confirm read data holds.
    req(1'b1, 1'b0, 28'h0000005, DataA, lat, rdat, err);
    check("wr5_lat", 128'(lat), 128'd4);
    check("wr5_rdata", rdat, 128'd0);
    req(1'b0, 1'b1, 28'h0000005, '0, lat, rdat, err);
    check("rd5_lat", 128'(lat), 128'd4);
    check("rd5_data", rdat, DataA);
    repeat (3) @(posedge clk);
    #1;
    check("rd5_hold", bus.mem_rdata, DataA);

    // Read held through GAP then switched to a write of line 6.
    first  = -1;
    second = -1;
    pulses = 0;
    rd2    = '0;
    bus.mem_read = 1'b1;
    bus.mem_addr = 28'h0000005;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        pulses++;
        if (first < 0) begin
          first = k;
        end else if (second < 0) begin
          second = k;
          rd2    = bus.mem_rdata;
        end
      end
      @(posedge clk);
      #1;
      if (k == 5) begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b1;
        bus.mem_addr  = 28'h0000006;
        bus.mem_wdata = Data6;
      end
      if (second >= 0) begin
        bus.mem_write = 1'b0;
      end
    end
    check("b2b_first", 128'(first), 128'd4);
    check("b2b_second", 128'(second), 128'd10);
    check("b2b_pulses", 128'(pulses), 128'd2);
    check("b2b_wr_keeps_rdata", rd2, DataA);
    req(1'b0, 1'b1, 28'h0000006, '0, lat, rdat, err);
    check("rd6_data", rdat, Data6);

    // Simultaneous read and write resolves as a write.
    req(1'b1, 1'b1, 28'h0000007, Ones, lat, rdat, err);
    check("both_lat", 128'(lat), 128'd4);
    check("both_rdata_kept", rdat, Data6);
    req(1'b0, 1'b1, 28'h0000007, '0, lat, rdat, err);
    check("rd7_data", rdat, Ones);

    // Reset in the middle of a write abandons it.
    req(1'b1, 1'b0, 28'h0000008, Fives, lat, rdat, err);
    check("wr8_lat", 128'(lat), 128'd4);
    bus.mem_write = 1'b1;
    bus.mem_addr  = 28'h0000008;
    bus.mem_wdata = As;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("abort_pre", 128'(bus.mem_ready), 128'd0);
      @(posedge clk);
      #1;
    end
    proc_reset    = 1'b1;
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("abort_rst_rdata", bus.mem_rdata, 128'd0);
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.mem_ready) pulses++;
      @(posedge clk);
      #1;
    end
    check("abort_no_ready", 128'(pulses), 128'd0);
    req(1'b0, 1'b1, 28'h0000008, '0, lat, rdat, err);
    check("rd8_data", rdat, Fives);
    check("rd8_err", 128'(err), 128'd0);

    // Upper address bits: alias by default, flagged and neutralised with range check.
    req(1'b1, 1'b0, 28'h0000105, DataP, lat, rdat, err);
    check("wr105_lat", 128'(lat), 128'd4);
`ifdef MEM_RANGE_CHECK_EN
    check("wr105_err", 128'(err), 128'd1);
    req(1'b0, 1'b1, 28'h0000005, '0, lat, rdat, err);
    check("rd5_unchanged", rdat, DataA);
    check("rd5_err", 128'(err), 128'd0);
    req(1'b0, 1'b1, 28'h0000105, '0, lat, rdat, err);
    check("rd105_err", 128'(err), 128'd1);
    check("rd105_zero", rdat, 128'd0);
`else
    req(1'b0, 1'b1, 28'h0000005, '0, lat, rdat, err);
    check("rd5_alias", rdat, DataP);
    req(1'b0, 1'b1, 28'h0000205, '0, lat, rdat, err);
    check("rd205_alias", rdat, DataP);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
